// File: rtl/prof_stamp_mc.sv
// Multi-channel profiling timestamper: round-robin command intake, record FIFO, single-beat AXI4 writer.
// Optional PROFSTAMP_DROP_EN: keep granting on a full FIFO and count discarded stamps instead of stalling.
module prof_stamp_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  input  logic [63:0]          offset,
  input  logic [NUM_CH*32-1:0] pN_TDATA,
  input  logic [NUM_CH-1:0]    pN_TVALID,
  output logic [NUM_CH-1:0]    pN_TREADY,
  output logic                 m_axi_gmem_AWVALID,
  input  logic                 m_axi_gmem_AWREADY,
  output logic [63:0]          m_axi_gmem_AWADDR,
  output logic [7:0]           m_axi_gmem_AWLEN,
  output logic [2:0]           m_axi_gmem_AWSIZE,
  output logic                 m_axi_gmem_WVALID,
  input  logic                 m_axi_gmem_WREADY,
  output logic [63:0]          m_axi_gmem_WDATA,
  output logic [7:0]           m_axi_gmem_WSTRB,
  output logic                 m_axi_gmem_WLAST,
  input  logic                 m_axi_gmem_BVALID,
  output logic                 m_axi_gmem_BREADY,
  input  logic [1:0]           m_axi_gmem_BRESP,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          stamp_count,
  output logic [31:0]          drop_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
`ifdef PROFSTAMP_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_RESP = 2'd2} wr_state_t;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    s = (s >= NUM_CH) ? (s - NUM_CH) : s;
    return CH_W'(s);
  endfunction

  logic [CNT_W-1:0]  ts_cnt_r;
  logic              busy_r, done_r;
  logic [63:0]       offset_r;
  logic [NUM_CH-1:0] running_r, running_next_s;
  logic [CH_W-1:0]   rr_ptr_r, gnt_idx_s;
  logic              gnt_found_s, arb_en_s;
  logic [NUM_CH-1:0] elig_s, tready_s;
  logic [3:0]        cmd_s;
  logic              start_acc_s, stamp_s, stop_s, push_s, pop_s, fin_s;
  logic [63:0]       record_s;
  logic [63:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     fifo_cnt_r, fifo_cnt_next_s;
  logic              fifo_full_s;
  wr_state_t         state_r, state_next_s;
  logic              aw_valid_r, w_valid_r;
  logic [63:0]       awaddr_r, wdata_r;
  logic [31:0]       wr_idx_r, stamp_cnt_r;
  logic              unused_s;

  assign unused_s    = ^{m_axi_gmem_BRESP, pN_TDATA};
  assign start_acc_s = start && !busy_r;
  assign fifo_full_s = (fifo_cnt_r == CW'(FIFO_DEPTH));
  assign arb_en_s    = busy_r && (DROP_EN || !fifo_full_s);
  assign elig_s      = pN_TVALID & running_r;
  assign cmd_s       = pN_TDATA[{gnt_idx_s, 5'b00000} +: 4];
  assign stamp_s     = gnt_found_s && (cmd_s == 4'h1);
  assign stop_s      = gnt_found_s && (cmd_s == 4'h2);
  assign push_s      = stamp_s && !fifo_full_s;
  assign pop_s       = (state_r == S_IDLE) && (fifo_cnt_r != {CW{1'b0}});
  assign record_s    = {5'b00000, 3'(gnt_idx_s), 56'(ts_cnt_r)};
  assign fifo_cnt_next_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);

  // Round-robin search starting at the pointer; first eligible channel wins.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_en_s && !gnt_found_s && elig_s[rr_idx(rr_ptr_r, k)]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = rr_idx(rr_ptr_r, k);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // One-hot ready for the granted channel only.
  always_comb begin
    tready_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      tready_s[i] = gnt_found_s && (gnt_idx_s == CH_W'(i));
    end
  end
  assign pN_TREADY = tready_s;

  // Channel run flags after this cycle's start/stop.
  always_comb begin
    running_next_s = running_r;
    if (start_acc_s) begin
      running_next_s = {NUM_CH{1'b1}};
    end else if (stop_s) begin
      running_next_s[gnt_idx_s] = 1'b0;
    end else begin
      running_next_s = running_r;
    end
  end

  // Writer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: state_next_s = pop_s ? S_ADDR : S_IDLE;
      S_ADDR: begin
        if ((!aw_valid_r || m_axi_gmem_AWREADY) && (!w_valid_r || m_axi_gmem_WREADY)) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_ADDR;
        end
      end
      S_RESP: state_next_s = m_axi_gmem_BVALID ? S_IDLE : S_RESP;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Completion is judged on next-cycle state so done lands right after the final event.
  assign fin_s = busy_r && (running_next_s == {NUM_CH{1'b0}}) &&
                 (fifo_cnt_next_s == {CW{1'b0}}) && (state_next_s == S_IDLE);

  // Session control, timestamp counter and arbitration state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ts_cnt_r  <= {CNT_W{1'b0}};
      offset_r  <= 64'd0;
      running_r <= {NUM_CH{1'b0}};
      rr_ptr_r  <= {CH_W{1'b0}};
    end else begin
      done_r    <= fin_s;
      running_r <= running_next_s;
      if (gnt_found_s) rr_ptr_r <= rr_idx(gnt_idx_s, 1);
      if (start_acc_s) begin
        busy_r   <= 1'b1;
        ts_cnt_r <= {CNT_W{1'b0}};
        offset_r <= offset;
      end else begin
        if (fin_s) busy_r <= 1'b0;
        if (busy_r) ts_cnt_r <= ts_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Record storage; occupancy is tracked by the pointers below.
  always_ff @(posedge ap_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= record_s;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      fifo_cnt_r <= fifo_cnt_next_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Writer datapath: one single-beat write outstanding at a time.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r     <= S_IDLE;
      aw_valid_r  <= 1'b0;
      w_valid_r   <= 1'b0;
      awaddr_r    <= 64'd0;
      wdata_r     <= 64'd0;
      wr_idx_r    <= 32'd0;
      stamp_cnt_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            aw_valid_r <= 1'b1;
            w_valid_r  <= 1'b1;
            awaddr_r   <= offset_r + {29'd0, wr_idx_r, 3'b000};
            wdata_r    <= mem_r[rd_ptr_r];
          end
        end
        S_ADDR: begin
          if (m_axi_gmem_AWREADY) aw_valid_r <= 1'b0;
          if (m_axi_gmem_WREADY)  w_valid_r  <= 1'b0;
        end
        S_RESP: begin
          if (m_axi_gmem_BVALID) begin
            wr_idx_r    <= wr_idx_r + 32'd1;
            stamp_cnt_r <= stamp_cnt_r + 32'd1;
          end
        end
        default: begin
          aw_valid_r <= 1'b0;
          w_valid_r  <= 1'b0;
        end
      endcase
      // Writer is always idle when a start can be accepted.
      if (start_acc_s) begin
        wr_idx_r    <= 32'd0;
        stamp_cnt_r <= 32'd0;
      end
    end
  end

`ifdef PROFSTAMP_DROP_EN
  logic        drop_s;
  logic [31:0] drop_cnt_r;
  assign drop_s = stamp_s && fifo_full_s;

  // Saturating count of stamps discarded on a full FIFO.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      drop_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      drop_cnt_r <= 32'd0;
    end else if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end
  assign drop_count = drop_cnt_r;
`else
  assign drop_count = 32'd0;
`endif

  assign m_axi_gmem_AWVALID = aw_valid_r;
  assign m_axi_gmem_AWADDR  = awaddr_r;
  assign m_axi_gmem_AWLEN   = 8'd0;
  assign m_axi_gmem_AWSIZE  = aw_valid_r ? 3'd3 : 3'd0;
  assign m_axi_gmem_WVALID  = w_valid_r;
  assign m_axi_gmem_WDATA   = wdata_r;
  assign m_axi_gmem_WSTRB   = w_valid_r ? 8'hFF : 8'h00;
  assign m_axi_gmem_WLAST   = w_valid_r;
  assign m_axi_gmem_BREADY  = (state_r == S_RESP);
  assign busy               = busy_r;
  assign done               = done_r;
  assign stamp_count        = stamp_cnt_r;

endmodule
